// File: rtl/bcd_display_driver_if.sv
// ---------------------------------------------------------------------------
// bcd_display_driver_if
// Bundles the request/result signals of the BCD display driver.
//   start     : request conversion of bin_in (one cycle, sampled on clk)
//   bin_in    : unsigned binary sample, WIDTH bits
//   busy      : conversion engine is shifting
//   done      : one-cycle pulse when bcd_out / HEX outputs update
//   overflow  : last completed conversion was saturated to 999
//   bcd_out   : {hundreds, tens, ones}
//   HEX0..2   : active-low segments {g,f,e,d,c,b,a} for ones/tens/hundreds
// master = producer of samples / consumer of display data (e.g. a bench)
// slave  = the driver itself
// ---------------------------------------------------------------------------
interface bcd_display_driver_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [11:0]      bcd_out;
    logic [6:0]       HEX0;
    logic [6:0]       HEX1;
    logic [6:0]       HEX2;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  overflow,
        input  bcd_out,
        input  HEX0,
        input  HEX1,
        input  HEX2
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output overflow,
        output bcd_out,
        output HEX0,
        output HEX1,
        output HEX2
    );
endinterface

// File: rtl/bcd_display_driver.sv
// ---------------------------------------------------------------------------
// bcd_display_driver
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// followed by registered seven-segment decoding of three digits.
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : slave side of bcd_display_driver_if (start/bin_in in;
//              busy/done/overflow/bcd_out/HEX0..HEX2 out)
// Parameters:
//   WIDTH    : binary input width (4..16); must match the interface WIDTH
//   BLANK_LZ : 1 = blank leading zeros on HEX2/HEX1
// Inputs above 999 are replaced by 999 before conversion and flagged.
// ---------------------------------------------------------------------------
module bcd_display_driver #(
    parameter int WIDTH    = 10,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    bcd_display_driver_if.slave   bus
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_VAL  = WIDTH'(999);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    // Upper digits come out of reset showing "blank" or "0" depending on
    // whether leading zeros are suppressed.
    localparam logic [6:0]       HEX_HI_RST = (BLANK_LZ != 0) ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [11:0]       scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [6:0]        hex0_q, hex0_d;
    logic [6:0]        hex1_q, hex1_d;
    logic [6:0]        hex2_q, hex2_d;

    logic [11:0]       scratch_adj;
    logic              in_over;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
    // that the carry lands in the next decimal digit. On the first shift the
    // scratch is zero, so the correction does nothing.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_add3
            always_comb begin
                if (scratch_q[gi*4 +: 4] >= 4'd5) begin
                    scratch_adj[gi*4 +: 4] = scratch_q[gi*4 +: 4] + 4'd3;
                end else begin
                    scratch_adj[gi*4 +: 4] = scratch_q[gi*4 +: 4];
                end
            end
        end
    endgenerate

    assign in_over = (32'(bus.bin_in) > 32'd999);

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (in_over) begin
                        shift_d    = SAT_VAL;
                        ovf_pend_d = 1'b1;
                    end else begin
                        shift_d    = bus.bin_in;
                        ovf_pend_d = 1'b0;
                    end
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {scratch_adj[10:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Segment decode works from the next bcd value so the HEX registers
    // update on the same edge as bcd_out.
    always_comb begin
        hex0_d = seg7(bcd_d[3:0]);
        hex1_d = seg7(bcd_d[7:4]);
        hex2_d = seg7(bcd_d[11:8]);
        if (BLANK_LZ != 0) begin
            if (bcd_d[11:8] == 4'd0) begin
                hex2_d = SEG_BLANK;
                if (bcd_d[7:4] == 4'd0) begin
                    hex1_d = SEG_BLANK;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= HEX_HI_RST;
            hex2_q     <= HEX_HI_RST;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.HEX0     = hex0_q;
    assign bus.HEX1     = hex1_q;
    assign bus.HEX2     = hex2_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_driver
// Scoreboard bench: the driver process pushes the expected display result of
// every accepted request; an independent monitor pops and compares on every
// done pulse. Expected values come from decimal arithmetic on the input.
// ---------------------------------------------------------------------------
module tb_bcd_display_driver;

    localparam int WIDTH = 10;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        int bcd;
        int ovf;
        int hex0;
        int hex1;
        int hex2;
        int scyc;
        int val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic [6:0] seg_tab [0:9];

    bcd_display_driver_if #(.WIDTH(WIDTH)) bus ();

    bcd_display_driver #(
        .WIDTH   (WIDTH),
        .BLANK_LZ(1)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: saturate, split into decimal digits, look up segments.
    function automatic exp_t model(input int v, input int scyc);
        exp_t e;
        int   s, h, t, o;
        s = (v > 999) ? 999 : v;
        h = s / 100;
        t = (s / 10) % 10;
        o = s % 10;
        e.bcd  = h * 256 + t * 16 + o;
        e.ovf  = (v > 999) ? 1 : 0;
        e.hex0 = int'(seg_tab[o]);
        e.hex1 = (h == 0 && t == 0) ? 'h7F : int'(seg_tab[t]);
        e.hex2 = (h == 0) ? 'h7F : int'(seg_tab[h]);
        e.scyc = scyc;
        e.val  = v;
        return e;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                chk("done_not_back_to_back", int'(prev_done), 0);
                chk("busy_low_with_done", int'(bus.busy), 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("bcd_out[%0d]", e.val), int'(bus.bcd_out), e.bcd);
                    chk($sformatf("overflow[%0d]", e.val), int'(bus.overflow), e.ovf);
                    chk($sformatf("HEX0[%0d]", e.val), int'(bus.HEX0), e.hex0);
                    chk($sformatf("HEX1[%0d]", e.val), int'(bus.HEX1), e.hex1);
                    chk($sformatf("HEX2[%0d]", e.val), int'(bus.HEX2), e.hex2);
                    chk($sformatf("latency[%0d]", e.val), cyc - e.scyc, LAT);
                    $display("conv in=%0d bcd=%03h ovf=%0d", e.val, bus.bcd_out, bus.overflow);
                end
            end
            prev_done = bus.done;
        end
    end

    // Called on a negedge: present the request for one cycle. Returns on the
    // negedge after the sampling edge.
    task automatic issue(input int v, input bit expect_accept);
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(v);
        @(negedge clk);
        bus.start = 1'b0;
        if (expect_accept) begin
            sb_q.push_back(model(v, cyc));
            chk("busy_after_start", int'(bus.busy), 1);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_ovf"}, int'(bus.overflow), 0);
        chk({tag, "_bcd"}, int'(bus.bcd_out), 0);
        chk({tag, "_hex0"}, int'(bus.HEX0), 'h40);
        chk({tag, "_hex1"}, int'(bus.HEX1), 'h7F);
        chk({tag, "_hex2"}, int'(bus.HEX2), 'h7F);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        cyc        = 0;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;

        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("idle_after_reset");

        // Single conversion of 255.
        issue(255, 1'b1);
        wait_done();
        @(negedge clk);

        // Exhaustive sweep, each start in the done cycle.
        for (int v = 0; v < 1024; v++) begin
            issue(v, 1'b1);
            wait_done();
        end
        @(negedge clk);

        // Leading-zero blanking cases.
        issue(7, 1'b1);
        wait_done();
        issue(40, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);

        // Request while busy is dropped.
        issue(123, 1'b1);
        @(negedge clk);
        @(negedge clk);
        issue(456, 1'b0);
        wait_done();
        repeat (LAT + 4) @(negedge clk);
        chk("no_queue_for_dropped", sb_q.size(), 0);

        // Reset mid-conversion aborts with no done pulse.
        issue(999, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        chk_reset_vals("after_abort");
        issue(1, 1'b1);
        wait_done();
        @(negedge clk);

        // Random values with random idle gaps.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(int'($urandom_range(0, 1023)), 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
